// File: rtl/lock_response_checker.sv
// lock_response_checker: checks the responses of a logic-locked adder for one
// key epoch. A start_i in IDLE latches key_i and clears the counters. Each
// accepted vector moves through a two-stage pipeline. The first stage registers
// the operands and the observed result. The second stage registers the compare
// against the true sum. After the last vector the FSM drains the pipeline and
// reports a one-cycle done_o pulse with the pass/fail verdict.
//
// Parameters: WIDTH (adder operand width), KEYW (key width), CNTW (counter width)
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start_i, key_i              open an epoch and latch the key
//   in_valid_i / in_ready_o     vector handshake (ready only in RUN)
//   add1_i, add2_i, result_i    operands and observed adder output
//   last_i                      final vector of the epoch
//   busy_o, done_o, pass_o      epoch status and verdict
//   key_o                       key of the current or last epoch
//   vec_cnt_o, err_cnt_o        saturating vector and mismatch counters
// Optional macro LOCK_CHK_FIRST_FAIL_CAPTURE_EN adds the fail_*_o outputs, which
// capture the first mismatching vector of the epoch together with its expected value.
module lock_response_checker #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned KEYW  = 32,
  parameter int unsigned CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [KEYW-1:0]  key_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic [WIDTH:0]   result_i,
  input  logic             last_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [KEYW-1:0]  key_o,
  output logic [CNTW-1:0]  vec_cnt_o,
  output logic [CNTW-1:0]  err_cnt_o
`ifdef LOCK_CHK_FIRST_FAIL_CAPTURE_EN
  ,
  output logic             fail_vld_o,
  output logic [WIDTH-1:0] fail_add1_o,
  output logic [WIDTH-1:0] fail_add2_o,
  output logic [WIDTH:0]   fail_result_o,
  output logic [WIDTH:0]   fail_exp_o
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [KEYW-1:0] key_q, key_d;
  logic [CNTW-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNTW-1:0] err_cnt_q, err_cnt_d;

  // Pipeline stage 1 (registered vector) and stage 2 (registered compare)
  logic             s1_vld_q;
  logic [WIDTH-1:0] s1_add1_q, s1_add2_q;
  logic [WIDTH:0]   s1_res_q;
  logic             s2_vld_q, s2_mis_q;
  logic [WIDTH:0]   exp_c;

  logic accept;
  logic start_ev;

  assign accept   = in_valid_i & in_ready_q;
  assign start_ev = (state_q == ST_IDLE) & start_i;
  assign exp_c    = (WIDTH+1)'(s1_add1_q) + (WIDTH+1)'(s1_add2_q);

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    vec_cnt_d  = vec_cnt_q;
    err_cnt_d  = err_cnt_q;
    pass_d     = pass_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE:   if (start_i) state_d = ST_RUN;
      ST_RUN:    if (accept && last_i) state_d = ST_DRAIN;
      ST_DRAIN:  state_d = ST_REPORT;
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (start_ev) begin
      key_d     = key_i;
      vec_cnt_d = '0;
      err_cnt_d = '0;
      pass_d    = 1'b0;
    end else begin
      if (s1_vld_q && (vec_cnt_q != {CNTW{1'b1}})) vec_cnt_d = vec_cnt_q + CNTW'(1);
      if (s2_vld_q && s2_mis_q && (err_cnt_q != {CNTW{1'b1}})) err_cnt_d = err_cnt_q + CNTW'(1);
      // The last compare retires on this edge, so the verdict uses err_cnt_d
      if (state_q == ST_REPORT) pass_d = (err_cnt_d == '0);
    end

    if (state_q == ST_REPORT) done_d = 1'b1;

    in_ready_d = (state_d == ST_RUN);
    busy_d     = (state_d != ST_IDLE);
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      key_q      <= '0;
      vec_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      key_q      <= key_d;
      vec_cnt_q  <= vec_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Compare pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_add1_q <= '0;
      s1_add2_q <= '0;
      s1_res_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_mis_q  <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_add1_q <= add1_i;
        s1_add2_q <= add2_i;
        s1_res_q  <= result_i;
      end
      s2_vld_q <= s1_vld_q;
      s2_mis_q <= s1_vld_q && (exp_c != s1_res_q);
    end
  end

`ifdef LOCK_CHK_FIRST_FAIL_CAPTURE_EN
  logic [WIDTH-1:0] s2_add1_q, s2_add2_q;
  logic [WIDTH:0]   s2_res_q, s2_exp_q;
  logic             fail_vld_q;
  logic [WIDTH-1:0] fail_add1_q, fail_add2_q;
  logic [WIDTH:0]   fail_res_q, fail_exp_q;

  // Stage-2 copy of the vector so a mismatch can be captured with its data
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_add1_q <= '0;
      s2_add2_q <= '0;
      s2_res_q  <= '0;
      s2_exp_q  <= '0;
    end else if (s1_vld_q) begin
      s2_add1_q <= s1_add1_q;
      s2_add2_q <= s1_add2_q;
      s2_res_q  <= s1_res_q;
      s2_exp_q  <= exp_c;
    end
  end

  // First-fail capture, cleared when a new epoch starts
  always_ff @(posedge clk) begin
    if (rst || start_ev) begin
      fail_vld_q  <= 1'b0;
      fail_add1_q <= '0;
      fail_add2_q <= '0;
      fail_res_q  <= '0;
      fail_exp_q  <= '0;
    end else if (s2_vld_q && s2_mis_q && !fail_vld_q) begin
      fail_vld_q  <= 1'b1;
      fail_add1_q <= s2_add1_q;
      fail_add2_q <= s2_add2_q;
      fail_res_q  <= s2_res_q;
      fail_exp_q  <= s2_exp_q;
    end
  end

  assign fail_vld_o    = fail_vld_q;
  assign fail_add1_o   = fail_add1_q;
  assign fail_add2_o   = fail_add2_q;
  assign fail_result_o = fail_res_q;
  assign fail_exp_o    = fail_exp_q;
`endif

  assign in_ready_o = in_ready_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign key_o      = key_q;
  assign vec_cnt_o  = vec_cnt_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_lock_response_checker.sv
// Testbench for lock_response_checker. Two instances share the stimulus: the
// default CNTW=8 instance and a CNTW=2 instance for saturation. Each epoch's
// expected verdict is pushed to a scoreboard queue as its last vector is driven.
// The expected verdict is popped and compared when done_o pulses.
module tb_lock_response_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] key_i;
  logic        in_valid_i;
  logic [15:0] add1_i, add2_i;
  logic [16:0] result_i;
  logic        last_i;

  logic        in_ready_o, busy_o, done_o, pass_o;
  logic [31:0] key_o;
  logic [7:0]  vec_cnt_o, err_cnt_o;

  logic        s_in_ready_o, s_busy_o, s_done_o, s_pass_o;
  logic [31:0] s_key_o;
  logic [1:0]  s_vec_cnt_o, s_err_cnt_o;

`ifdef LOCK_CHK_FIRST_FAIL_CAPTURE_EN
  logic        fail_vld_o;
  logic [15:0] fail_add1_o, fail_add2_o;
  logic [16:0] fail_result_o, fail_exp_o;
  logic        s_fail_vld_o;
  logic [15:0] s_fail_add1_o, s_fail_add2_o;
  logic [16:0] s_fail_result_o, s_fail_exp_o;
`endif

  always #5 clk = ~clk;

  lock_response_checker #(.WIDTH(16), .KEYW(32), .CNTW(8)) u_dut (
    .clk(clk), .rst(rst), .start_i(start_i), .key_i(key_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .add1_i(add1_i), .add2_i(add2_i), .result_i(result_i), .last_i(last_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .key_o(key_o),
    .vec_cnt_o(vec_cnt_o), .err_cnt_o(err_cnt_o)
`ifdef LOCK_CHK_FIRST_FAIL_CAPTURE_EN
    , .fail_vld_o(fail_vld_o), .fail_add1_o(fail_add1_o), .fail_add2_o(fail_add2_o),
    .fail_result_o(fail_result_o), .fail_exp_o(fail_exp_o)
`endif
  );

  lock_response_checker #(.WIDTH(16), .KEYW(32), .CNTW(2)) u_sat (
    .clk(clk), .rst(rst), .start_i(start_i), .key_i(key_i),
    .in_valid_i(in_valid_i), .in_ready_o(s_in_ready_o),
    .add1_i(add1_i), .add2_i(add2_i), .result_i(result_i), .last_i(last_i),
    .busy_o(s_busy_o), .done_o(s_done_o), .pass_o(s_pass_o), .key_o(s_key_o),
    .vec_cnt_o(s_vec_cnt_o), .err_cnt_o(s_err_cnt_o)
`ifdef LOCK_CHK_FIRST_FAIL_CAPTURE_EN
    , .fail_vld_o(s_fail_vld_o), .fail_add1_o(s_fail_add1_o), .fail_add2_o(s_fail_add2_o),
    .fail_result_o(s_fail_result_o), .fail_exp_o(s_fail_exp_o)
`endif
  );

  typedef struct {
    logic        pass;
    logic [7:0]  vec;
    logic [7:0]  err;
    logic [1:0]  vec2;
    logic [1:0]  err2;
    logic [31:0] key;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   m_vec, m_err;
  logic [31:0] m_key;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic open_epoch(input logic [31:0] k);
    start_i = 1'b1; key_i = k;
    cyc();
    start_i = 1'b0;
    m_vec = 0; m_err = 0; m_key = k;
  endtask

  // Drive one accepted vector; update the model and push a verdict on last
  task automatic send_vec(input logic [15:0] a, input logic [15:0] b,
                          input logic [16:0] r, input logic lst);
    logic [16:0] s;
    exp_t e;
    add1_i = a; add2_i = b; result_i = r; last_i = lst; in_valid_i = 1'b1;
    cyc();
    in_valid_i = 1'b0; last_i = 1'b0;
    s = {1'b0, a} + {1'b0, b};
    m_vec++;
    if (s != r) m_err++;
    if (lst) begin
      e.pass = (m_err == 0);
      e.vec  = 8'(m_vec > 255 ? 255 : m_vec);
      e.err  = 8'(m_err > 255 ? 255 : m_err);
      e.vec2 = 2'(m_vec > 3 ? 3 : m_vec);
      e.err2 = 2'(m_err > 3 ? 3 : m_err);
      e.key  = m_key;
      sbq.push_back(e);
    end
  endtask

  // Wait for the verdict, pop the scoreboard, compare verdict and latency
  task automatic wait_done(input string nm);
    int   lat;
    bit   seen;
    exp_t e;
    seen = 0; lat = 0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      cyc();
      if (done_o) begin seen = 1; lat = i; end
    end
    n_cmp++;
    if (!seen || sbq.size() == 0) begin
      n_fail++;
      $display("FAIL %s_done: done seen=%0d queued=%0d, required done within 8 cycles", nm, seen, sbq.size());
      return;
    end
    e = sbq.pop_front();
    n_cmp++;
    if (lat !== 2) begin n_fail++; $display("FAIL %s_latency: got %0d required 2", nm, lat); end
    n_cmp++;
    if ({pass_o, vec_cnt_o, err_cnt_o, key_o} !== {e.pass, e.vec, e.err, e.key}) begin
      n_fail++;
      $display("FAIL %s_verdict: got pass=%0d vec=%0d err=%0d key=%h required pass=%0d vec=%0d err=%0d key=%h",
               nm, pass_o, vec_cnt_o, err_cnt_o, key_o, e.pass, e.vec, e.err, e.key);
    end
    n_cmp++;
    if ({s_done_o, s_pass_o, s_vec_cnt_o, s_err_cnt_o} !== {1'b1, e.pass, e.vec2, e.err2}) begin
      n_fail++;
      $display("FAIL %s_sat_verdict: got done=%0d pass=%0d vec=%0d err=%0d required done=1 pass=%0d vec=%0d err=%0d",
               nm, s_done_o, s_pass_o, s_vec_cnt_o, s_err_cnt_o, e.pass, e.vec2, e.err2);
    end
    cyc();
    cyc();
    n_cmp++;
    if ({done_o, busy_o, pass_o, vec_cnt_o, err_cnt_o} !== {1'b0, 1'b0, e.pass, e.vec, e.err}) begin
      n_fail++;
      $display("FAIL %s_hold: got done=%0d busy=%0d pass=%0d vec=%0d err=%0d required done=0 busy=0 pass=%0d vec=%0d err=%0d",
               nm, done_o, busy_o, pass_o, vec_cnt_o, err_cnt_o, e.pass, e.vec, e.err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; key_i = '0; in_valid_i = 1'b0;
    add1_i = '0; add2_i = '0; result_i = '0; last_i = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    n_cmp++;
    if ({in_ready_o, busy_o, done_o, pass_o, key_o, vec_cnt_o, err_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%0d busy=%0d done=%0d pass=%0d key=%h vec=%0d err=%0d required all 0",
               in_ready_o, busy_o, done_o, pass_o, key_o, vec_cnt_o, err_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    open_epoch(32'hF17B83DB);
    n_cmp++;
    if ({in_ready_o, busy_o, pass_o, vec_cnt_o} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL start_state: got rdy=%0d busy=%0d pass=%0d vec=%0d required rdy=1 busy=1 pass=0 vec=0",
               in_ready_o, busy_o, pass_o, vec_cnt_o);
    end
    send_vec(16'h29AF, 16'h7A1B, 17'h0A3CA, 1'b0);
    send_vec(16'h8943, 16'hFFFF, 17'h18942, 1'b0);
    send_vec(16'h5555, 16'hAAAA, 17'h0FFFF, 1'b1);
    wait_done("good_epoch");
  endtask

  task automatic test_one_bad();
    open_epoch(32'hF17B83DB);
    send_vec(16'h29AF, 16'h7A1B, 17'h0A3CA, 1'b0);
    send_vec(16'h8943, 16'hFFFF, 17'h08942, 1'b0);
    send_vec(16'h5555, 16'hAAAA, 17'h0FFFF, 1'b1);
    wait_done("bad_epoch");
`ifdef LOCK_CHK_FIRST_FAIL_CAPTURE_EN
    n_cmp++;
    if ({fail_vld_o, fail_add1_o, fail_add2_o, fail_exp_o, fail_result_o} !==
        {1'b1, 16'h8943, 16'hFFFF, 17'h18942, 17'h08942}) begin
      n_fail++;
      $display("FAIL first_fail: got vld=%0d a1=%h a2=%h exp=%h res=%h required vld=1 a1=8943 a2=ffff exp=18942 res=08942",
               fail_vld_o, fail_add1_o, fail_add2_o, fail_exp_o, fail_result_o);
    end
    open_epoch(32'h0000_0001);
    n_cmp++;
    if (fail_vld_o !== 1'b0) begin
      n_fail++;
      $display("FAIL first_fail_clear: got vld=%0d required 0", fail_vld_o);
    end
    send_vec(16'h0001, 16'h0001, 17'h00002, 1'b1);
    wait_done("clear_epoch");
`endif
  endtask

  task automatic test_saturation();
    logic [15:0] a;
    open_epoch(32'h5A5A_A5A5);
    for (int i = 0; i < 5; i++) begin
      a = 16'($urandom_range(0, 65535));
      send_vec(a, 16'h1234, ({1'b0, a} + 17'h01234) ^ 17'h00001, i == 4);
    end
    wait_done("saturation");
  endtask

  task automatic test_gapped();
    open_epoch(32'hCAFE_0004);
    for (int i = 0; i < 4; i++) begin
      send_vec(16'(i * 16'h1111), 16'hF00F, {1'b0, 16'(i * 16'h1111)} + 17'h0F00F, i == 3);
      if (i != 3) cyc();
    end
    wait_done("gapped");
  endtask

  task automatic test_reset_mid_epoch();
    int dones;
    open_epoch(32'h1357_9BDF);
    send_vec(16'h0003, 16'h0004, 17'h00009, 1'b0);
    send_vec(16'h0005, 16'h0006, 17'h0000B, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready_o, busy_o, done_o, pass_o, key_o, vec_cnt_o, err_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_state: got rdy=%0d busy=%0d done=%0d pass=%0d key=%h vec=%0d err=%0d required all 0",
               in_ready_o, busy_o, done_o, pass_o, key_o, vec_cnt_o, err_cnt_o);
    end
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (done_o || s_done_o) dones++;
    end
    n_cmp++;
    if ({dones, err_cnt_o, vec_cnt_o} !== {32'd0, 8'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL mid_reset_quiet: got dones=%0d err=%0d vec=%0d required 0 0 0", dones, err_cnt_o, vec_cnt_o);
    end
  endtask

  task automatic test_ignored();
    logic [7:0] prev_vec;
    open_epoch(32'h0BAD_F00D);
    send_vec(16'h0010, 16'h0020, 17'h00030, 1'b1);
    wait_done("pre_ignored");
    prev_vec = 8'(m_vec);
    // Vector in IDLE must not be counted
    add1_i = 16'h1111; add2_i = 16'h2222; result_i = 17'h00000; last_i = 1'b1; in_valid_i = 1'b1;
    cyc();
    in_valid_i = 1'b0; last_i = 1'b0;
    cyc(); cyc();
    n_cmp++;
    if ({vec_cnt_o, busy_o} !== {prev_vec, 1'b0}) begin
      n_fail++;
      $display("FAIL idle_valid: got vec=%0d busy=%0d required vec=%0d busy=0", vec_cnt_o, busy_o, prev_vec);
    end
    // start with a coinciding final vector: epoch opens, vector not accepted
    in_valid_i = 1'b1; last_i = 1'b1;
    open_epoch(32'hAAAA_0001);
    in_valid_i = 1'b0; last_i = 1'b0;
    cyc(); cyc();
    n_cmp++;
    if ({vec_cnt_o, busy_o, in_ready_o} !== {8'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL start_with_vec: got vec=%0d busy=%0d rdy=%0d required vec=0 busy=1 rdy=1", vec_cnt_o, busy_o, in_ready_o);
    end
    // start in RUN must not reload the key
    start_i = 1'b1; key_i = 32'hBBBB_0002;
    cyc();
    start_i = 1'b0;
    cyc();
    n_cmp++;
    if ({key_o, vec_cnt_o} !== {32'hAAAA_0001, 8'd0}) begin
      n_fail++;
      $display("FAIL run_start: got key=%h vec=%0d required key=aaaa0001 vec=0", key_o, vec_cnt_o);
    end
    send_vec(16'hFFFF, 16'h0001, 17'h10000, 1'b1);
    wait_done("after_ignored");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_one_bad();
    test_saturation();
    test_gapped();
    test_reset_mid_epoch();
    test_ignored();
    n_cmp++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
